// File: rtl/cdb_lane_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// cdb_lane_scheduler_pkg
// Shared constants and types for the CDB lane scheduler slice.
//   CDB_LANES            number of common data bus lanes (fixed at two)
//   NUM_REQ_DEFAULT      default number of requesting combos
//   STARVE_LIMIT_DEFAULT default wait cycles before a requester is forced ahead
//   lane_idx_t           one-bit lane index
//   idx_bits()           owner/pointer width for a given requester count
// -----------------------------------------------------------------------------
package cdb_lane_scheduler_pkg;

  localparam int CDB_LANES            = 2;
  localparam int NUM_REQ_DEFAULT      = 4;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  typedef logic lane_idx_t;

  // Width of a requester index; never zero so a single requester still has a bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_lane_scheduler_if.sv
// -----------------------------------------------------------------------------
// cdb_lane_scheduler_if
// Request/grant bundle between the combos and the CDB lane scheduler.
//   i_flush       pipeline flush, drops the grant being decided
//   i_req         per-requester "result ready" flags
//   i_lane_stall  per-lane back-pressure for the decision cycle
//   o_grant       per-requester one-cycle grant
//   o_bus_index   lane owned by each granted requester
//   o_lane_valid  per-lane broadcast valid
//   o_lane_owner  requester driving each lane
// modport master: the requesting side; modport slave: the scheduler.
// -----------------------------------------------------------------------------
interface cdb_lane_scheduler_if
  import cdb_lane_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int IDX_BITS = idx_bits(NUM_REQ)
);

  logic                                 i_flush;
  logic [NUM_REQ-1:0]                   i_req;
  logic [CDB_LANES-1:0]                 i_lane_stall;
  logic [NUM_REQ-1:0]                   o_grant;
  logic [NUM_REQ-1:0]                   o_bus_index;
  logic [CDB_LANES-1:0]                 o_lane_valid;
  logic [CDB_LANES-1:0][IDX_BITS-1:0]   o_lane_owner;

  modport master (
    output i_flush, i_req, i_lane_stall,
    input  o_grant, o_bus_index, o_lane_valid, o_lane_owner
  );

  modport slave (
    input  i_flush, i_req, i_lane_stall,
    output o_grant, o_bus_index, o_lane_valid, o_lane_owner
  );

endinterface

// File: rtl/cdb_lane_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// cdb_lane_scheduler_rr_pick
// Masked find-first-set starting at a rotating pointer: returns the first set
// bit of mask visiting pointer, pointer+1, ... with wrap-around.
//   mask     candidate requesters
//   pointer  position searched first
//   found    at least one mask bit set
//   index    position of the first hit (zero when nothing found)
// -----------------------------------------------------------------------------
module cdb_lane_scheduler_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  mask,
  input  logic [IDX_BITS-1:0] pointer,
  output logic                found,
  output logic [IDX_BITS-1:0] index
);

  // Walk the rotation backwards so the hit nearest the pointer is written last.
  always_comb begin : search
    logic [IDX_BITS-1:0] pos;
    pos   = {IDX_BITS{1'b0}};
    found = 1'b0;
    index = {IDX_BITS{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = IDX_BITS'((int'(pointer) + k) % NUM_REQ);
      if (mask[pos]) begin
        found = 1'b1;
        index = pos;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/cdb_lane_scheduler.sv
// -----------------------------------------------------------------------------
// cdb_lane_scheduler
// Central scheduler for the two CDB lanes. Each cycle it picks up to two
// eligible requesters (starved ones first, then round-robin from the pointer),
// binds them to the free lanes and registers one-cycle grants.
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    cdb_lane_scheduler_if.slave (requests, stalls, flush, grants)
// -----------------------------------------------------------------------------
module cdb_lane_scheduler
  import cdb_lane_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int IDX_BITS     = idx_bits(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  cdb_lane_scheduler_if.slave     bus
);

  localparam int                  CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(STARVE_LIMIT);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  ONE_BIT  = NUM_REQ'(1'b1);

  // Registered state
  logic [NUM_REQ-1:0]                 grant_r;
  logic [NUM_REQ-1:0]                 bus_index_r;
  logic [CDB_LANES-1:0]               lane_valid_r;
  logic [CDB_LANES-1:0][IDX_BITS-1:0] lane_owner_r;
  logic [IDX_BITS-1:0]                ptr_r;
  logic [NUM_REQ-1:0][CNT_BITS-1:0]   cnt_r;

  // Decision-cycle signals
  logic [NUM_REQ-1:0]                 elig_s;
  logic [NUM_REQ-1:0]                 starved_s;
  logic                               st1_found_s, nm1_found_s, st2_found_s, nm2_found_s;
  logic [IDX_BITS-1:0]                st1_idx_s, nm1_idx_s, st2_idx_s, nm2_idx_s;
  logic                               pick1_found_s, pick2_found_s;
  logic [IDX_BITS-1:0]                pick1_idx_s, pick2_idx_s, last_pick_s;
  logic [NUM_REQ-1:0]                 excl1_s;
  logic [CDB_LANES-1:0]               lane_avail_s;
  lane_idx_t                          first_lane_s;
  logic                               take1_s, take2_s;
  logic [NUM_REQ-1:0]                 next_grant_s;
  logic [NUM_REQ-1:0]                 next_bus_index_s;
  logic [CDB_LANES-1:0]               next_lane_valid_s;
  logic [CDB_LANES-1:0][IDX_BITS-1:0] next_lane_owner_s;
  logic [IDX_BITS-1:0]                next_ptr_s;
  logic [NUM_REQ-1:0][CNT_BITS-1:0]   next_cnt_s;

  // The current grantee is masked so a still-high request is not counted twice.
  assign elig_s = bus.i_req & ~grant_r;

  // Starved requesters are eligible ones whose wait counter has saturated.
  always_comb begin
    starved_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      starved_s[i] = elig_s[i] & (cnt_r[i] == CNT_MAX);
    end
  end

  cdb_lane_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS)) u_pick_st1 (
    .mask(starved_s), .pointer(ptr_r), .found(st1_found_s), .index(st1_idx_s)
  );

  cdb_lane_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS)) u_pick_nm1 (
    .mask(elig_s), .pointer(ptr_r), .found(nm1_found_s), .index(nm1_idx_s)
  );

  assign pick1_found_s = st1_found_s | nm1_found_s;
  assign pick1_idx_s   = st1_found_s ? st1_idx_s : nm1_idx_s;
  // Second search excludes the first pick so nobody receives both lanes.
  assign excl1_s       = pick1_found_s ? (ONE_BIT << pick1_idx_s) : {NUM_REQ{1'b0}};

  cdb_lane_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS)) u_pick_st2 (
    .mask(starved_s & ~excl1_s), .pointer(ptr_r), .found(st2_found_s), .index(st2_idx_s)
  );

  cdb_lane_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS)) u_pick_nm2 (
    .mask(elig_s & ~excl1_s), .pointer(ptr_r), .found(nm2_found_s), .index(nm2_idx_s)
  );

  assign pick2_found_s = st2_found_s | nm2_found_s;
  assign pick2_idx_s   = st2_found_s ? st2_idx_s : nm2_idx_s;

  // The first pick takes the lowest free lane; a second pick needs both lanes free.
  assign lane_avail_s = ~bus.i_lane_stall;
  assign first_lane_s = lane_avail_s[0] ? 1'b0 : 1'b1;
  assign take1_s      = pick1_found_s & (|lane_avail_s) & ~bus.i_flush;
  assign take2_s      = pick2_found_s & (&lane_avail_s) & ~bus.i_flush;

  // Build next grant/lane outputs; index and owner hold where nothing is granted.
  always_comb begin
    next_grant_s      = {NUM_REQ{1'b0}};
    next_lane_valid_s = {CDB_LANES{1'b0}};
    next_bus_index_s  = bus_index_r;
    next_lane_owner_s = lane_owner_r;
    if (take1_s) begin
      next_grant_s[pick1_idx_s]           = 1'b1;
      next_bus_index_s[pick1_idx_s]       = first_lane_s;
      next_lane_valid_s[first_lane_s]     = 1'b1;
      next_lane_owner_s[first_lane_s]     = pick1_idx_s;
    end else begin
      next_grant_s = {NUM_REQ{1'b0}};
    end
    if (take2_s) begin
      next_grant_s[pick2_idx_s]           = 1'b1;
      next_bus_index_s[pick2_idx_s]       = 1'b1;
      next_lane_valid_s[1'b1]             = 1'b1;
      next_lane_owner_s[1'b1]             = pick2_idx_s;
    end else begin
      next_lane_valid_s = next_lane_valid_s;
    end
  end

  // Pointer moves past the last granted requester; held when nothing is granted.
  always_comb begin
    last_pick_s = take2_s ? pick2_idx_s : pick1_idx_s;
    if (!take1_s) begin
      next_ptr_s = ptr_r;
    end else if (last_pick_s == LAST_IDX) begin
      next_ptr_s = {IDX_BITS{1'b0}};
    end else begin
      next_ptr_s = last_pick_s + IDX_BITS'(1);
    end
  end

  // Saturating wait counters: cleared on grant, idle request or flush.
  always_comb begin
    next_cnt_s = cnt_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.i_flush || !bus.i_req[i] || next_grant_s[i]) begin
        next_cnt_s[i] = {CNT_BITS{1'b0}};
      end else if (elig_s[i] && (cnt_r[i] != CNT_MAX)) begin
        next_cnt_s[i] = cnt_r[i] + CNT_BITS'(1);
      end else begin
        next_cnt_s[i] = cnt_r[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r      <= {NUM_REQ{1'b0}};
      bus_index_r  <= {NUM_REQ{1'b0}};
      lane_valid_r <= {CDB_LANES{1'b0}};
      lane_owner_r <= {(CDB_LANES*IDX_BITS){1'b0}};
      ptr_r        <= {IDX_BITS{1'b0}};
      cnt_r        <= {(NUM_REQ*CNT_BITS){1'b0}};
    end else begin
      grant_r      <= next_grant_s;
      bus_index_r  <= next_bus_index_s;
      lane_valid_r <= next_lane_valid_s;
      lane_owner_r <= next_lane_owner_s;
      ptr_r        <= next_ptr_s;
      cnt_r        <= next_cnt_s;
    end
  end

  assign bus.o_grant      = grant_r;
  assign bus.o_bus_index  = bus_index_r;
  assign bus.o_lane_valid = lane_valid_r;
  assign bus.o_lane_owner = lane_owner_r;

endmodule

// File: tb/tb_cdb_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cdb_lane_scheduler
// Two scheduler instances (starve limit 8 and 2) checked against a queue-based
// reference model, a directed vector table and a starvation sequence.
// -----------------------------------------------------------------------------
module tb_cdb_lane_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cdb_lane_scheduler_if #(.NUM_REQ(4)) bus_a ();
  cdb_lane_scheduler_if #(.NUM_REQ(4)) bus_b ();

  cdb_lane_scheduler #(.NUM_REQ(4), .STARVE_LIMIT(8)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  cdb_lane_scheduler #(.NUM_REQ(4), .STARVE_LIMIT(2)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  typedef struct packed {
    logic [3:0]      grant;
    logic [3:0]      bidx;
    logic [1:0]      lv;
    logic [1:0][1:0] owner;
    logic [1:0]      ptr;
    logic [3:0][3:0] cnt;
  } mstate_t;

  typedef struct packed {
    logic       rst;
    logic       fl;
    logic [3:0] req;
    logic [1:0] stall;
    logic [3:0] g;
    logic [1:0] lv;
    logic [3:0] bidx;
    logic [3:0] own;
  } vec_t;

  mstate_t ma, mb;
  vec_t    vecs [15];

  // Reference: order starved-then-normal eligible requesters rotating from the
  // pointer, zip them with the free lanes, then update pointer and counters.
  function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic fl,
                                         input logic [3:0] req, input logic [1:0] stall,
                                         input int limit);
    mstate_t    n;
    int         order[$];
    int         lanes[$];
    int         take;
    int         p;
    int         c;
    logic [3:0] elig;
    n = s;
    if (rst) begin
      n = '0;
      return n;
    end
    elig = req & ~s.grant;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (int'(s.ptr) + k) % 4;
        if (elig[i] && ((int'(s.cnt[i]) == limit) == (pass == 0))) order.push_back(i);
      end
    end
    for (int l = 0; l < 2; l++) if (!stall[l]) lanes.push_back(l);
    take = fl ? 0 : ((order.size() < lanes.size()) ? order.size() : lanes.size());
    n.grant = '0;
    n.lv    = '0;
    for (int j = 0; j < take; j++) begin
      p = order[j];
      n.grant[p]        = 1'b1;
      n.bidx[p]         = (lanes[j] == 1);
      n.lv[lanes[j]]    = 1'b1;
      n.owner[lanes[j]] = 2'(p);
      n.ptr             = 2'((p + 1) % 4);
    end
    for (int i = 0; i < 4; i++) begin
      c = int'(s.cnt[i]);
      if (fl || !req[i] || n.grant[i]) c = 0;
      else if (elig[i] && c < limit) c = c + 1;
      n.cnt[i] = 4'(c);
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vs_model(input string tag, input logic [3:0] g, input logic [1:0] lv,
                                input logic [3:0] bidx, input logic [1:0][1:0] own,
                                input mstate_t m);
    check({tag, ".grant"}, 32'(g), 32'(m.grant));
    check({tag, ".lane_valid"}, 32'(lv), 32'(m.lv));
    for (int l = 0; l < 2; l++)
      if (m.lv[l]) check($sformatf("%s.owner%0d", tag, l), 32'(own[l]), 32'(m.owner[l]));
    for (int i = 0; i < 4; i++)
      if (m.grant[i]) check($sformatf("%s.bus_index%0d", tag, i), 32'(bidx[i]), 32'(m.bidx[i]));
  endtask

  // Advance one clock with both models stepped on the inputs the DUTs sample.
  task automatic tick();
    ma = model_step(ma, reset, bus_a.i_flush, bus_a.i_req, bus_a.i_lane_stall, 8);
    mb = model_step(mb, reset, bus_b.i_flush, bus_b.i_req, bus_b.i_lane_stall, 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit got3;

    //               rst   fl    req      stall  g        lv     bidx     own{l1,l0}
    vecs[0]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 4'b0011, 2'b11, 4'b0010, 4'b0100};
    vecs[1]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 4'b1100, 2'b11, 4'b1000, 4'b1110};
    vecs[2]  = '{1'b0, 1'b0, 4'b0100, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 1'b0, 4'b0100, 2'b00, 4'b0100, 2'b01, 4'b0000, 4'b0010};
    vecs[4]  = '{1'b0, 1'b0, 4'b0100, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b0, 1'b0, 4'b0100, 2'b00, 4'b0100, 2'b01, 4'b0000, 4'b0010};
    vecs[6]  = '{1'b0, 1'b0, 4'b0011, 2'b01, 4'b0001, 2'b10, 4'b0001, 4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 4'b0011, 2'b01, 4'b0010, 2'b10, 4'b0010, 4'b0100};
    vecs[8]  = '{1'b0, 1'b0, 4'b0011, 2'b11, 4'b0000, 2'b00, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 1'b1, 4'b0011, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000};
    vecs[10] = '{1'b0, 1'b0, 4'b0011, 2'b00, 4'b0011, 2'b11, 4'b0010, 4'b0100};
    vecs[11] = '{1'b1, 1'b0, 4'b1111, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000};
    vecs[12] = '{1'b0, 1'b0, 4'b1000, 2'b00, 4'b1000, 2'b01, 4'b0000, 4'b0011};
    vecs[13] = '{1'b0, 1'b0, 4'b0110, 2'b10, 4'b0010, 2'b01, 4'b0000, 4'b0001};
    vecs[14] = '{1'b0, 1'b0, 4'b0110, 2'b10, 4'b0100, 2'b01, 4'b0000, 4'b0010};

    reset = 1'b1;
    bus_a.i_flush = 1'b0; bus_a.i_req = 4'b0000; bus_a.i_lane_stall = 2'b00;
    bus_b.i_flush = 1'b0; bus_b.i_req = 4'b0000; bus_b.i_lane_stall = 2'b00;
    ma = '0;
    mb = '0;
    tick();
    tick();
    reset = 1'b0;

    check("reset.grant",      32'(bus_a.o_grant),      32'd0);
    check("reset.lane_valid", 32'(bus_a.o_lane_valid), 32'd0);
    check("reset.bus_index",  32'(bus_a.o_bus_index),  32'd0);
    check("reset.owner",      32'(bus_a.o_lane_owner), 32'd0);

    // Directed vector table on instance A.
    for (int v = 0; v < 15; v++) begin
      reset              = vecs[v].rst;
      bus_a.i_flush      = vecs[v].fl;
      bus_a.i_req        = vecs[v].req;
      bus_a.i_lane_stall = vecs[v].stall;
      tick();
      check($sformatf("vec%0d.grant", v), 32'(bus_a.o_grant), 32'(vecs[v].g));
      check($sformatf("vec%0d.lane_valid", v), 32'(bus_a.o_lane_valid), 32'(vecs[v].lv));
      check($sformatf("vec%0d.bus_index", v), 32'(bus_a.o_bus_index & vecs[v].g), 32'(vecs[v].bidx));
      for (int l = 0; l < 2; l++)
        if (vecs[v].lv[l])
          check($sformatf("vec%0d.owner%0d", v, l), 32'(bus_a.o_lane_owner[l]), 32'(vecs[v].own[l*2 +: 2]));
      if (vecs[v].rst) begin
        check($sformatf("vec%0d.rst_bus_index", v), 32'(bus_a.o_bus_index), 32'd0);
        check($sformatf("vec%0d.rst_owner", v), 32'(bus_a.o_lane_owner), 32'd0);
      end
      check_vs_model($sformatf("vec%0d.model", v), bus_a.o_grant, bus_a.o_lane_valid,
                     bus_a.o_bus_index, bus_a.o_lane_owner, ma);
    end
    reset = 1'b0;

    // Random phase: requesters hold their request until granted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus_a.i_req[i] || ma.grant[i]) bus_a.i_req[i] = ($urandom_range(0, 99) < 55);
        if (!bus_b.i_req[i] || mb.grant[i]) bus_b.i_req[i] = ($urandom_range(0, 99) < 70);
      end
      bus_a.i_lane_stall = {($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 25)};
      bus_b.i_lane_stall = {($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 20)};
      bus_a.i_flush      = ($urandom_range(0, 99) < 4);
      bus_b.i_flush      = ($urandom_range(0, 99) < 3);
      reset              = ($urandom_range(0, 299) == 0);
      tick();
      check_vs_model("rand_a", bus_a.o_grant, bus_a.o_lane_valid, bus_a.o_bus_index, bus_a.o_lane_owner, ma);
      check_vs_model("rand_b", bus_b.o_grant, bus_b.o_lane_valid, bus_b.o_bus_index, bus_b.o_lane_owner, mb);
    end

    // Starvation on instance B: lane1 stalled, reqs 0-2 always re-requesting.
    bus_a.i_req = 4'b0000; bus_a.i_flush = 1'b0; bus_a.i_lane_stall = 2'b00;
    bus_b.i_req = 4'b0000; bus_b.i_flush = 1'b0; bus_b.i_lane_stall = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_b.i_req        = 4'b1111;
    bus_b.i_lane_stall = 2'b10;
    lat  = 0;
    got3 = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check_vs_model($sformatf("starve%0d", t), bus_b.o_grant, bus_b.o_lane_valid,
                     bus_b.o_bus_index, bus_b.o_lane_owner, mb);
      if (!got3 && bus_b.o_grant[3]) begin
        got3 = 1'b1;
        lat  = t;
      end
      if (mb.grant[3]) bus_b.i_req[3] = 1'b0;
    end
    check("starve.req3_latency", 32'(lat), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
